// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-latched, maskable, fixed-priority interrupt controller with ack/EOI handshake
module irq_ctrl #(
  parameter int          N_IRQ    = 8,
  parameter int          NUM_W    = 3,
  parameter logic [15:0] VEC_BASE = 16'h0000
) (
  input  logic             I_clk,
  input  logic             I_reset,
  input  logic [N_IRQ-1:0] I_irq_lines,
  input  logic             I_mask_we,
  input  logic [N_IRQ-1:0] I_mask_data,
  input  logic             I_irq_ack,
  input  logic             I_eoi,
  output logic             O_irq_active,
  output logic [NUM_W-1:0] O_irq_number,
  output logic [15:0]      O_irq_vector,
  output logic             O_num_valid,
  output logic [N_IRQ-1:0] O_pending,
  output logic             O_spurious
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, ACKED = 2'd2, IN_SERVICE = 2'd3;
  logic [1:0]       state;
  logic [N_IRQ-1:0] pending, mask, prev_lines, selectable, rise, clr;
  logic [NUM_W-1:0] sel;
  logic             take;
  assign selectable = pending & mask;
  assign rise       = I_irq_lines & ~prev_lines;
  assign take       = state == REQ && I_irq_ack && |selectable;
  assign clr        = take ? N_IRQ'(1) << sel : '0;
  assign O_pending  = pending;
  // lowest selectable index wins; scanning downward leaves the lowest one last
  always_comb begin
    sel = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (selectable[i]) sel = NUM_W'(i);
  end
  // edge capture, pending set/clear (a same-cycle edge beats the clear) and mask register
  always_ff @(posedge I_clk or negedge I_reset)
    if (!I_reset) begin
      prev_lines <= '0;
      pending    <= '0;
      mask       <= '0;
    end else begin
      prev_lines <= I_irq_lines;
      pending    <= (pending & ~clr) | rise;
      if (I_mask_we) mask <= I_mask_data;
    end
  // request/acknowledge/service handshake with the control unit
  always_ff @(posedge I_clk or negedge I_reset)
    if (!I_reset) begin
      state        <= IDLE;
      O_irq_active <= 1'b0;
      O_irq_number <= '0;
      O_irq_vector <= '0;
      O_num_valid  <= 1'b0;
      O_spurious   <= 1'b0;
    end else begin
      O_spurious <= I_irq_ack && (state == IDLE || state == IN_SERVICE || (state == REQ && ~|selectable));
      case (state)
        IDLE:
          if (|selectable) begin
            state        <= REQ;
            O_irq_active <= 1'b1;
          end
        REQ:
          if (~|selectable) begin
            state        <= IDLE;
            O_irq_active <= 1'b0;
          end else if (I_irq_ack) begin
            state        <= ACKED;
            O_irq_active <= 1'b0;
            O_num_valid  <= 1'b1;
            O_irq_number <= sel;
            O_irq_vector <= VEC_BASE + 16'(sel);
          end
        ACKED:
          if (!I_irq_ack) state <= IN_SERVICE;
        default:
          if (I_eoi) begin
            state       <= IDLE;
            O_num_valid <= 1'b0;
          end
      endcase
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl (vector base chosen to exercise wrap)
module tb_irq_ctrl;
  logic       I_clk = 1'b0, I_reset = 1'b0;
  logic [7:0] I_irq_lines = '0, I_mask_data = '0;
  logic       I_mask_we = 1'b0, I_irq_ack = 1'b0, I_eoi = 1'b0;
  logic       O_irq_active, O_num_valid, O_spurious;
  logic [2:0] O_irq_number;
  logic [15:0] O_irq_vector;
  logic [7:0] O_pending;
  int compared = 0, mismatched = 0;
  irq_ctrl #(.N_IRQ(8), .NUM_W(3), .VEC_BASE(16'hFFFC)) dut (
    .I_clk(I_clk), .I_reset(I_reset), .I_irq_lines(I_irq_lines), .I_mask_we(I_mask_we),
    .I_mask_data(I_mask_data), .I_irq_ack(I_irq_ack), .I_eoi(I_eoi), .O_irq_active(O_irq_active),
    .O_irq_number(O_irq_number), .O_irq_vector(O_irq_vector), .O_num_valid(O_num_valid),
    .O_pending(O_pending), .O_spurious(O_spurious)
  );
  always #5 I_clk = ~I_clk;
  task automatic tick(input int n = 1);
    repeat (n) @(posedge I_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_mask(input logic [7:0] m);
    I_mask_we = 1'b1; I_mask_data = m; tick(); I_mask_we = 1'b0;
  endtask
  task automatic pulse(input logic [7:0] l);
    I_irq_lines = l; tick(); I_irq_lines = '0;
  endtask
  task automatic finish_service();
    I_irq_ack = 1'b0; tick(); I_eoi = 1'b1; tick(); I_eoi = 1'b0;
  endtask
  initial begin
    tick(2);
    chk("rst_active", 16'(O_irq_active), 16'd0);
    chk("rst_number", 16'(O_irq_number), 16'd0);
    chk("rst_vector", O_irq_vector, 16'h0000);
    chk("rst_valid", 16'(O_num_valid), 16'd0);
    chk("rst_pending", 16'(O_pending), 16'h00);
    I_reset = 1'b1; tick();
    set_mask(8'hFF);
    pulse(8'h20);
    chk("t1_pending", 16'(O_pending), 16'h20);
    chk("t1_active_early", 16'(O_irq_active), 16'd0);
    tick();
    chk("t1_active", 16'(O_irq_active), 16'd1);
    I_irq_ack = 1'b1; tick();
    chk("t1_number", 16'(O_irq_number), 16'd5);
    chk("t1_vector_wrap", O_irq_vector, 16'h0001);
    chk("t1_valid", 16'(O_num_valid), 16'd1);
    chk("t1_active_drop", 16'(O_irq_active), 16'd0);
    chk("t1_pending_clr", 16'(O_pending), 16'h00);
    finish_service();
    chk("t1_valid_eoi", 16'(O_num_valid), 16'd0);
    pulse(8'h44);
    tick();
    chk("t2_active", 16'(O_irq_active), 16'd1);
    I_irq_ack = 1'b1; tick();
    chk("t2_number_first", 16'(O_irq_number), 16'd2);
    chk("t2_vector_first", O_irq_vector, 16'hFFFE);
    chk("t2_pending_left", 16'(O_pending), 16'h40);
    finish_service();
    chk("t2_idle_after_eoi", 16'(O_irq_active), 16'd0);
    tick();
    chk("t2_active_second", 16'(O_irq_active), 16'd1);
    I_irq_ack = 1'b1; tick();
    chk("t2_number_second", 16'(O_irq_number), 16'd6);
    chk("t2_vector_second", O_irq_vector, 16'h0002);
    finish_service();
    set_mask(8'h00);
    pulse(8'h08);
    tick(2);
    chk("t3_masked_active", 16'(O_irq_active), 16'd0);
    chk("t3_masked_pending", 16'(O_pending), 16'h08);
    set_mask(8'h08);
    chk("t3_mask_delay", 16'(O_irq_active), 16'd0);
    tick();
    chk("t3_active", 16'(O_irq_active), 16'd1);
    I_irq_ack = 1'b1; tick();
    chk("t3_number", 16'(O_irq_number), 16'd3);
    chk("t3_vector", O_irq_vector, 16'hFFFF);
    finish_service();
    set_mask(8'hFF);
    pulse(8'h02);
    tick();
    I_irq_ack = 1'b1; tick();
    chk("t4_number_line1", 16'(O_irq_number), 16'd1);
    I_irq_ack = 1'b0; tick();
    pulse(8'h01);
    tick(2);
    chk("t4_no_nesting", 16'(O_irq_active), 16'd0);
    chk("t4_pending0", 16'(O_pending), 16'h01);
    chk("t4_valid_held", 16'(O_num_valid), 16'd1);
    I_eoi = 1'b1; tick(); I_eoi = 1'b0;
    tick();
    chk("t4_active_after_eoi", 16'(O_irq_active), 16'd1);
    I_irq_ack = 1'b1; tick();
    chk("t4_number0", 16'(O_irq_number), 16'd0);
    chk("t4_vector0", O_irq_vector, 16'hFFFC);
    finish_service();
    I_irq_ack = 1'b1; tick();
    chk("t5_spurious", 16'(O_spurious), 16'd1);
    chk("t5_spur_active", 16'(O_irq_active), 16'd0);
    I_irq_ack = 1'b0; tick();
    chk("t5_spurious_end", 16'(O_spurious), 16'd0);
    chk("t5_spur_valid", 16'(O_num_valid), 16'd0);
    pulse(8'h10);
    tick();
    I_irq_ack = 1'b1; I_irq_lines = 8'h80; tick(); I_irq_lines = '0;
    chk("t5_number4", 16'(O_irq_number), 16'd4);
    chk("t5_vector4", O_irq_vector, 16'h0000);
    tick(3);
    chk("t5_hold_number", 16'(O_irq_number), 16'd4);
    chk("t5_hold_pending", 16'(O_pending), 16'h80);
    chk("t5_hold_active", 16'(O_irq_active), 16'd0);
    chk("t5_hold_spurious", 16'(O_spurious), 16'd0);
    finish_service();
    tick();
    chk("t5_line7_active", 16'(O_irq_active), 16'd1);
    I_irq_ack = 1'b1; tick();
    chk("t5_number7", 16'(O_irq_number), 16'd7);
    I_irq_ack = 1'b0; tick();
    pulse(8'h11);
    chk("t6_pending_pre", 16'(O_pending), 16'h11);
    chk("t6_valid_pre", 16'(O_num_valid), 16'd1);
    #2 I_reset = 1'b0;
    #1;
    chk("t6_active", 16'(O_irq_active), 16'd0);
    chk("t6_number", 16'(O_irq_number), 16'd0);
    chk("t6_vector", O_irq_vector, 16'h0000);
    chk("t6_valid", 16'(O_num_valid), 16'd0);
    chk("t6_pending", 16'(O_pending), 16'h00);
    chk("t6_spurious", 16'(O_spurious), 16'd0);
    tick();
    I_reset = 1'b1; tick(2);
    chk("t6_idle_active", 16'(O_irq_active), 16'd0);
    set_mask(8'hFF);
    pulse(8'h04);
    tick();
    chk("t6_new_active", 16'(O_irq_active), 16'd1);
    I_irq_ack = 1'b1; tick(); I_irq_ack = 1'b0;
    chk("t6_new_number", 16'(O_irq_number), 16'd2);
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
